// File: rtl/pipeline_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl_pkg
// Description : Shared types for the pipeline hazard controller and the
//               pipeline registers it drives (controller state, per-stage
//               load/flush control word).
// Revision    : 1.0  initial release
// ============================================================================
package pipeline_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        RECOVER  = 2'd2
    } hazard_state_t;

    typedef struct packed {
        logic load;
        logic flush;
    } stage_ctrl_t;

    // Recover counter only has to hold 1..3.
    localparam int c_RECOVER_CNT_W = 2;

    localparam stage_ctrl_t c_STAGE_HOLD    = '{load: 1'b0, flush: 1'b0};
    localparam stage_ctrl_t c_STAGE_ADVANCE = '{load: 1'b1, flush: 1'b0};
    localparam stage_ctrl_t c_STAGE_SQUASH  = '{load: 1'b1, flush: 1'b1};

endpackage
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_perf_counters.sv
`default_nettype none
// ============================================================================
// Module      : hazard_perf_counters
// Description : Three saturating event counters (memory stall cycles,
//               branch mispredicts, load-use bubbles). Instantiated by
//               pipeline_hazard_ctrl only when PIPE_HAZARD_PERF_EN is defined.
// Revision    : 1.0  initial release
// ============================================================================
module hazard_perf_counters #(
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_inc,
    input  logic              mispred_inc,
    input  logic              load_use_inc,
    output logic [PERF_W-1:0] stall_cnt,
    output logic [PERF_W-1:0] mispredict_cnt,
    output logic [PERF_W-1:0] load_use_cnt
);

    logic [PERF_W-1:0] r_stall_cnt;
    logic [PERF_W-1:0] r_mispredict_cnt;
    logic [PERF_W-1:0] r_load_use_cnt;

    // Count events, holding at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt      <= '0;
            r_mispredict_cnt <= '0;
            r_load_use_cnt   <= '0;
        end else begin
            if (stall_inc && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + PERF_W'(1);
            if (mispred_inc && (r_mispredict_cnt != '1))
                r_mispredict_cnt <= r_mispredict_cnt + PERF_W'(1);
            if (load_use_inc && (r_load_use_cnt != '1))
                r_load_use_cnt <= r_load_use_cnt + PERF_W'(1);
        end
    end

    assign stall_cnt      = r_stall_cnt;
    assign mispredict_cnt = r_mispredict_cnt;
    assign load_use_cnt   = r_load_use_cnt;

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl
// Description : Central stall/flush controller for a 5-stage pipeline.
//               Drives PC, IF/ID, ID/EX, EX/MEM and MEM/WB load/flush,
//               the PC redirect select and a one-shot predictor update.
//               Priority: memory stall > mispredict > load-use.
//               Optional performance counters: define PIPE_HAZARD_PERF_EN.
// Revision    : 1.0  initial release
// ============================================================================
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W     = 5,
    parameter int RECOVER_CYCLES = 1,
    parameter int PERF_W         = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_using_rs1,
    input  logic                  id_using_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_read,
    input  logic                  ex_br,
    input  logic                  ex_jump,
    input  logic                  ex_br_taken,
    input  logic                  ex_p_outcome,
    input  logic                  imem_busy,
    input  logic                  dmem_busy,
    output logic                  pc_load,
    output logic                  if_id_load,
    output logic                  if_id_flush,
    output logic                  id_ex_load,
    output logic                  id_ex_flush,
    output logic                  ex_mem_load,
    output logic                  mem_wb_load,
    output logic                  redirect,
    output logic                  bp_update,
    output logic                  bp_mispredict,
    output logic [PERF_W-1:0]     stall_cnt,
    output logic [PERF_W-1:0]     mispredict_cnt,
    output logic [PERF_W-1:0]     load_use_cnt
);

    localparam logic [c_RECOVER_CNT_W-1:0] c_RECOVER_INIT =
        c_RECOVER_CNT_W'(RECOVER_CYCLES);

    hazard_state_t              r_state;
    hazard_state_t              w_state_nxt;
    logic [c_RECOVER_CNT_W-1:0] r_rec_cnt;
    logic [c_RECOVER_CNT_W-1:0] w_rec_cnt_nxt;
    logic                       r_resolved;

    logic        w_mem_stall;
    logic        w_load_use;
    logic        w_mispred;
    logic        w_pc_load;
    stage_ctrl_t w_if_id;
    stage_ctrl_t w_id_ex;
    logic        w_ex_mem_load;
    logic        w_mem_wb_load;
    logic        w_redirect;
    logic        w_bp_update;

    assign w_mem_stall = imem_busy | dmem_busy;
    assign w_load_use  = ex_mem_read && (ex_rd != '0) &&
                         ((id_using_rs1 && (id_rs1 == ex_rd)) ||
                          (id_using_rs2 && (id_rs2 == ex_rd)));
    assign w_mispred   = ex_jump | (ex_br & (ex_br_taken ^ ex_p_outcome));

    // Next state and per-stage controls; MEM_WAIT decides exactly like RUN
    // once the stall drops so no idle cycle is lost on release.
    always_comb begin
        w_state_nxt   = r_state;
        w_rec_cnt_nxt = r_rec_cnt;
        w_pc_load     = 1'b0;
        w_if_id       = c_STAGE_HOLD;
        w_id_ex       = c_STAGE_HOLD;
        w_ex_mem_load = 1'b0;
        w_mem_wb_load = 1'b0;
        w_redirect    = 1'b0;
        case (r_state)
            RUN, MEM_WAIT: begin
                if (w_mem_stall) begin
                    w_state_nxt = MEM_WAIT;
                end else if (w_mispred) begin
                    w_pc_load     = 1'b1;
                    w_if_id       = c_STAGE_SQUASH;
                    w_id_ex       = c_STAGE_SQUASH;
                    w_ex_mem_load = 1'b1;
                    w_mem_wb_load = 1'b1;
                    w_redirect    = 1'b1;
                    w_rec_cnt_nxt = c_RECOVER_INIT;
                    w_state_nxt   = RECOVER;
                end else if (w_load_use) begin
                    // PC and IF/ID hold; a single bubble enters EX.
                    w_id_ex       = c_STAGE_SQUASH;
                    w_ex_mem_load = 1'b1;
                    w_mem_wb_load = 1'b1;
                    w_state_nxt   = RUN;
                end else begin
                    w_pc_load     = 1'b1;
                    w_if_id       = c_STAGE_ADVANCE;
                    w_id_ex       = c_STAGE_ADVANCE;
                    w_ex_mem_load = 1'b1;
                    w_mem_wb_load = 1'b1;
                    w_state_nxt   = RUN;
                end
            end
            RECOVER: begin
                // Squash wrong-path fetches; ID only ever holds NOPs here.
                if (!w_mem_stall) begin
                    w_pc_load     = 1'b1;
                    w_if_id       = c_STAGE_SQUASH;
                    w_id_ex       = c_STAGE_ADVANCE;
                    w_ex_mem_load = 1'b1;
                    w_mem_wb_load = 1'b1;
                    if (r_rec_cnt < c_RECOVER_CNT_W'(2)) begin
                        w_rec_cnt_nxt = '0;
                        w_state_nxt   = RUN;
                    end else begin
                        w_rec_cnt_nxt = r_rec_cnt - c_RECOVER_CNT_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt   = RUN;
                w_rec_cnt_nxt = '0;
            end
        endcase
    end

    // One update per control-transfer instruction as it leaves EX.
    assign w_bp_update = (ex_br | ex_jump) & w_ex_mem_load & ~w_mem_stall & ~r_resolved;

    // State, recover counter and resolved flag (cleared when a new
    // instruction enters ID/EX so back-to-back branches each get a pulse).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= RUN;
            r_rec_cnt  <= '0;
            r_resolved <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_rec_cnt <= w_rec_cnt_nxt;
            if (w_id_ex.load)
                r_resolved <= 1'b0;
            else if (w_bp_update)
                r_resolved <= 1'b1;
        end
    end

    // Everything is forced low while reset is asserted to freeze the pipe.
    assign pc_load       = rst & w_pc_load;
    assign if_id_load    = rst & w_if_id.load;
    assign if_id_flush   = rst & w_if_id.flush;
    assign id_ex_load    = rst & w_id_ex.load;
    assign id_ex_flush   = rst & w_id_ex.flush;
    assign ex_mem_load   = rst & w_ex_mem_load;
    assign mem_wb_load   = rst & w_mem_wb_load;
    assign redirect      = rst & w_redirect;
    assign bp_update     = rst & w_bp_update;
    assign bp_mispredict = rst & w_bp_update & w_mispred;

`ifdef PIPE_HAZARD_PERF_EN
    // A load-use bubble is the only case that squashes ID/EX while IF/ID holds.
    logic w_lu_bubble;
    assign w_lu_bubble = rst & w_id_ex.flush & ~w_if_id.load;

    hazard_perf_counters #(
        .PERF_W (PERF_W)
    ) u_perf (
        .clk            (clk),
        .rst            (rst),
        .stall_inc      (w_mem_stall),
        .mispred_inc    (bp_mispredict),
        .load_use_inc   (w_lu_bubble),
        .stall_cnt      (stall_cnt),
        .mispredict_cnt (mispredict_cnt),
        .load_use_cnt   (load_use_cnt)
    );
`else
    assign stall_cnt      = '0;
    assign mispredict_cnt = '0;
    assign load_use_cnt   = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_hazard_ctrl
// Description : Self-checking bench. Two controllers share one stimulus:
//               A (RECOVER_CYCLES=1, PERF_W=32) and B (RECOVER_CYCLES=3,
//               PERF_W=2). A behavioural model tracks remaining squash
//               cycles per instance and predicts every output each cycle.
// Revision    : 1.0  initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

`ifdef PIPE_HAZARD_PERF_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_using_rs1, id_using_rs2, ex_mem_read, ex_br, ex_jump;
    logic       ex_br_taken, ex_p_outcome, imem_busy, dmem_busy;

    logic        pc_a, ifl_a, iff_a, idl_a, idf_a, em_a, mw_a, rd_a, bpu_a, bpm_a;
    logic        pc_b, ifl_b, iff_b, idl_b, idf_b, em_b, mw_b, rd_b, bpu_b, bpm_b;
    logic [31:0] st_a, mc_a, lc_a;
    logic [1:0]  st_b, mc_b, lc_b;
    logic [9:0]  out_a, out_b;

    assign out_a = {pc_a, ifl_a, iff_a, idl_a, idf_a, em_a, mw_a, rd_a, bpu_a, bpm_a};
    assign out_b = {pc_b, ifl_b, iff_b, idl_b, idf_b, em_b, mw_b, rd_b, bpu_b, bpm_b};

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.REG_ADDR_W(5), .RECOVER_CYCLES(1), .PERF_W(32)) dut_a (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_using_rs1(id_using_rs1), .id_using_rs2(id_using_rs2), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .ex_br(ex_br), .ex_jump(ex_jump),
        .ex_br_taken(ex_br_taken), .ex_p_outcome(ex_p_outcome),
        .imem_busy(imem_busy), .dmem_busy(dmem_busy),
        .pc_load(pc_a), .if_id_load(ifl_a), .if_id_flush(iff_a), .id_ex_load(idl_a),
        .id_ex_flush(idf_a), .ex_mem_load(em_a), .mem_wb_load(mw_a), .redirect(rd_a),
        .bp_update(bpu_a), .bp_mispredict(bpm_a),
        .stall_cnt(st_a), .mispredict_cnt(mc_a), .load_use_cnt(lc_a)
    );

    pipeline_hazard_ctrl #(.REG_ADDR_W(5), .RECOVER_CYCLES(3), .PERF_W(2)) dut_b (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_using_rs1(id_using_rs1), .id_using_rs2(id_using_rs2), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .ex_br(ex_br), .ex_jump(ex_jump),
        .ex_br_taken(ex_br_taken), .ex_p_outcome(ex_p_outcome),
        .imem_busy(imem_busy), .dmem_busy(dmem_busy),
        .pc_load(pc_b), .if_id_load(ifl_b), .if_id_flush(iff_b), .id_ex_load(idl_b),
        .id_ex_flush(idf_b), .ex_mem_load(em_b), .mem_wb_load(mw_b), .redirect(rd_b),
        .bp_update(bpu_b), .bp_mispredict(bpm_b),
        .stall_cnt(st_b), .mispredict_cnt(mc_b), .load_use_cnt(lc_b)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string nm, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    // Output bit order: pc, if_id_load, if_id_flush, id_ex_load, id_ex_flush,
    // ex_mem_load, mem_wb_load, redirect, bp_update, bp_mispredict.
    int     m_rec [2];   // squash cycles still owed after a redirect
    bit     m_done[2];   // instruction now in EX already reported
    longint m_st[2], m_mc[2], m_lc[2];

    function automatic int rc(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic longint sat(input int i);
        return (i == 0) ? 64'h0000_0000_FFFF_FFFF : 64'd3;
    endfunction

    function automatic bit f_ms();
        return imem_busy || dmem_busy;
    endfunction

    function automatic bit f_mp();
        return ex_jump || (ex_br && (ex_br_taken != ex_p_outcome));
    endfunction

    function automatic bit f_lu();
        return ex_mem_read && (ex_rd != 0) &&
               ((id_using_rs1 && id_rs1 == ex_rd) || (id_using_rs2 && id_rs2 == ex_rd));
    endfunction

    function automatic logic [9:0] model_out(input int rec, input bit done);
        logic [9:0] o;
        o = '0;
        if (!rst || f_ms())  o = '0;
        else if (rec > 0)    o[9:3] = 7'b1111011;
        else if (f_mp())     o[9:2] = 8'b11111111;
        else if (f_lu())     o[9:3] = 7'b0001111;
        else                 o[9:3] = 7'b1101011;
        if (rst && !f_ms() && (ex_br || ex_jump) && o[4] && !done) begin
            o[1] = 1'b1;
            o[0] = f_mp();
        end
        return o;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                m_rec[i] = 0; m_done[i] = 1'b0;
                m_st[i] = 0; m_mc[i] = 0; m_lc[i] = 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                logic [9:0] e;
                e = model_out(m_rec[i], m_done[i]);
                if (f_ms() && m_st[i] < sat(i)) m_st[i]++;
                if (e[1] && e[0] && m_mc[i] < sat(i)) m_mc[i]++;
                if (e[9:3] == 7'b0001111 && m_lc[i] < sat(i)) m_lc[i]++;
                if (e[6]) m_done[i] = 1'b0;
                else if (e[1]) m_done[i] = 1'b1;
                if (!f_ms()) begin
                    if (m_rec[i] > 0) m_rec[i]--;
                    else if (f_mp()) m_rec[i] = rc(i);
                end
            end
        end
    end

    // Compare both instances against the model every cycle.
    always @(negedge clk) begin
        check("outs_A", 96'(out_a), 96'(model_out(m_rec[0], m_done[0])));
        check("outs_B", 96'(out_b), 96'(model_out(m_rec[1], m_done[1])));
        check("cnt_A", {st_a, mc_a, lc_a},
              PERF_ON ? {m_st[0][31:0], m_mc[0][31:0], m_lc[0][31:0]} : 96'd0);
        check("cnt_B", 96'({st_b, mc_b, lc_b}),
              PERF_ON ? 96'({m_st[1][1:0], m_mc[1][1:0], m_lc[1][1:0]}) : 96'd0);
    end

    // ---------------- stimulus ----------------
    task automatic clr();
        id_rs1 = 0; id_rs2 = 0; ex_rd = 0; id_using_rs1 = 0; id_using_rs2 = 0;
        ex_mem_read = 0; ex_br = 0; ex_jump = 0; ex_br_taken = 0; ex_p_outcome = 0;
        imem_busy = 0; dmem_busy = 0;
    endtask

    task automatic nxt();
        @(posedge clk); #1; clr();
    endtask

    task automatic lit(input string nm, input logic [9:0] e);
        #2; check(nm, 96'(out_a), 96'(e));
    endtask

    task automatic mispredict_in();
        ex_br = 1; ex_br_taken = 1; ex_p_outcome = 0;
    endtask

    int n_upd;

    initial begin
        clr();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_A", 96'(out_a), 96'd0);
        check("reset_B", 96'(out_b), 96'd0);
        rst = 1'b1;
        #2;
        check("idle_A", 96'(out_a), 96'(10'b1101011000));

        nxt(); ex_mem_read = 1; ex_rd = 5; id_using_rs1 = 1; id_rs1 = 5;
        lit("load_use", 10'b0001111000);
        nxt(); lit("after_load_use", 10'b1101011000);
        nxt(); ex_mem_read = 1; ex_rd = 0; id_using_rs1 = 1; id_rs1 = 0;
        lit("rd0_no_stall", 10'b1101011000);

        nxt(); mispredict_in(); lit("mispred_c0", 10'b1111111111);
        nxt(); lit("mispred_c1", 10'b1111011000);
        nxt(); lit("mispred_c2", 10'b1101011000);
        repeat (3) nxt();

        nxt(); ex_br = 1; ex_br_taken = 1; ex_p_outcome = 1;
        lit("correct_pred", 10'b1101011010);
        repeat (3) nxt();

        n_upd = 0;
        for (int k = 0; k < 4; k++) begin
            nxt(); dmem_busy = 1; mispredict_in();
            lit("mem_stall_frozen", 10'b0000000000);
            n_upd += int'(bpu_a);
        end
        nxt(); mispredict_in(); lit("stall_release", 10'b1111111111);
        n_upd += int'(bpu_a);
        check("stall_single_update", 96'(n_upd), 96'd1);
        repeat (4) nxt();

        nxt(); mispredict_in(); #2;
        check("B_mispred", 96'(out_b), 96'(10'b1111111111));
        nxt(); rst = 1'b0; #1;
        check("B_reset_in_recover", 96'(out_b), 96'd0);
        nxt(); rst = 1'b1; #2;
        check("B_after_reset", 96'(out_b), 96'(10'b1101011000));

        repeat (3) begin nxt(); imem_busy = 1; end
        nxt();
        nxt(); mispredict_in();
        repeat (4) nxt();
        nxt(); ex_jump = 1;
        repeat (4) nxt();
        nxt(); ex_mem_read = 1; ex_rd = 7; id_using_rs2 = 1; id_rs2 = 7;
        nxt(); #2;
        check("perf_A_3_2_1", {st_a, mc_a, lc_a},
              PERF_ON ? {32'd3, 32'd2, 32'd1} : 96'd0);
        check("perf_B_3_2_1", 96'({st_b, mc_b, lc_b}),
              PERF_ON ? 96'({2'd3, 2'd2, 2'd1}) : 96'd0);
        repeat (2) begin nxt(); dmem_busy = 1; end
        nxt(); #2;
        check("perf_A_stall5", 96'(st_a), PERF_ON ? 96'd5 : 96'd0);
        check("perf_B_stall_sat", 96'(st_b), PERF_ON ? 96'd3 : 96'd0);

        for (int k = 0; k < 3000; k++) begin
            nxt();
            rst          = ($urandom_range(0, 299) != 0);
            id_rs1       = 5'($urandom_range(0, 3));
            id_rs2       = 5'($urandom_range(0, 3));
            ex_rd        = 5'($urandom_range(0, 3));
            id_using_rs1 = ($urandom_range(0, 1) == 1);
            id_using_rs2 = ($urandom_range(0, 1) == 1);
            ex_mem_read  = ($urandom_range(0, 2) == 0);
            ex_br        = ($urandom_range(0, 3) == 0);
            ex_jump      = ($urandom_range(0, 9) == 0);
            ex_br_taken  = ($urandom_range(0, 1) == 1);
            ex_p_outcome = ($urandom_range(0, 1) == 1);
            imem_busy    = ($urandom_range(0, 9) == 0);
            dmem_busy    = ($urandom_range(0, 11) == 0);
        end
        nxt(); rst = 1'b1;
        repeat (4) nxt();
        @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush controller that drives the load and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC register.
- Consumes hazard-relevant fields from the ID stage and from the ID/EX register outputs: rd, mem_read, using_rs*, branch and jump resolution, prediction outcome.
- Decides the per-cycle advance, hold, bubble or squash for every pipeline stage.
- Emits exactly one branch-predictor update pulse per resolved branch.

Parameters:
REG_ADDR_W, 5, register index width
RECOVER_CYCLES, 1, extra wrong-path fetch cycles squashed after a redirect (legal 1..3)
PERF_W, 32, width of performance counters (used only with the optional feature)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
id_rs1  in  REG_ADDR_W  rs1 of the instruction in ID
id_rs2  in  REG_ADDR_W  rs2 of the instruction in ID
id_using_rs1  in  1  ID instruction reads rs1
id_using_rs2  in  1  ID instruction reads rs2
ex_rd  in  REG_ADDR_W  rd held in ID/EX
ex_mem_read  in  1  ID/EX instruction is a load
ex_br  in  1  ID/EX instruction is a conditional branch
ex_jump  in  1  ID/EX instruction is jal/jalr
ex_br_taken  in  1  comparator result in EX
ex_p_outcome  in  1  predicted direction carried in ID/EX
imem_busy  in  1  instruction fetch not yet returned
dmem_busy  in  1  MEM-stage data access not yet returned
pc_load  out  1  PC register enable
if_id_load  out  1  IF/ID enable
if_id_flush  out  1  IF/ID loads NOP
id_ex_load  out  1  ID/EX enable
id_ex_flush  out  1  ID/EX loads NOP (bubble)
ex_mem_load  out  1  EX/MEM enable
mem_wb_load  out  1  MEM/WB enable
redirect  out  1  PC mux selects EX target/fall-through
bp_update  out  1  one-cycle predictor update strobe
bp_mispredict  out  1  qualifies bp_update: prediction was wrong
stall_cnt, mispredict_cnt, load_use_cnt  out  PERF_W each  performance counters

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to RUN; recover counter and resolved flag clear.
  - All outputs are 0 while rst=0, including every load enable, so the pipeline is frozen.
- Definitions:
  - mem_stall = imem_busy | dmem_busy.
  - load_use = ex_mem_read & ex_rd!=0 & ((id_using_rs1 & id_rs1==ex_rd) | (id_using_rs2 & id_rs2==ex_rd)).
  - mispred = ex_jump | (ex_br & (ex_br_taken != ex_p_outcome)).
- Priority is mem_stall > mispred > load_use.
- State RUN:
  - mem_stall: all five loads=0, flushes=0, redirect=0. Go to MEM_WAIT.
  - mispred: all loads=1, redirect=1, if_id_flush=1, id_ex_flush=1. Load the recover counter with RECOVER_CYCLES. Go to RECOVER.
  - load_use only: pc_load=0, if_id_load=0, id_ex_load=1 with id_ex_flush=1, ex_mem_load=mem_wb_load=1. Stay in RUN; exactly 1 bubble is inserted.
  - None of the above: all loads=1.
- State MEM_WAIT:
  - All loads=0 while mem_stall.
  - When mem_stall drops, evaluate mispred and load_use in that same cycle exactly as in RUN, then leave MEM_WAIT. There is no extra idle cycle.
- State RECOVER:
  - All loads=1, if_id_flush=1, id_ex_flush=0.
  - The counter decrements; return to RUN when it reaches 1.
  - mem_stall in RECOVER freezes the counter and all loads=0. State is retained, and the squash resumes when mem_stall drops.
  - A load_use is impossible in RECOVER because ID holds a squashed NOP; no load_use bubble is inserted.
- Predictor update:
  - bp_update=1 in the cycle an ex_br or ex_jump instruction advances out of EX (ex_mem_load=1 and not under mem_stall).
  - bp_mispredict=mispred in that cycle.
  - A registered resolved flag guarantees a single pulse per instruction even across multi-cycle freezes. It is set on the pulse and cleared when id_ex_load=1.
- ex_rd=0 never causes a load_use stall.
- Latency: all outputs are combinational from inputs plus state; state changes on the clk rising edge.

Optional Feature:
- PIPE_HAZARD_PERF_EN defined:
  - stall_cnt increments on every cycle with mem_stall.
  - mispredict_cnt increments on every bp_update with bp_mispredict.
  - load_use_cnt increments on every inserted load_use bubble.
  - Counters saturate at all-ones and reset to 0.
- Not defined: counters are not instantiated and the three outputs are tied to 0.

Decomposition:
- Shared package: hazard_state_t enum (RUN, MEM_WAIT, RECOVER) and a stage_ctrl_t struct (load, flush) reused by the pipeline registers.
- One natural sub-module: hazard_perf_counters, instantiated only under PIPE_HAZARD_PERF_EN.

Test Plan:
- Load-use:
  - Stimulus: ex_mem_read=1, ex_rd=5, id_using_rs1=1, id_rs1=5.
  - Response: one cycle with pc_load=0, if_id_load=0, id_ex_flush=1; the next cycle has all loads=1.
  - Repeat with ex_rd=0: no stall.
- Branch mispredict:
  - Stimulus: ex_br=1, ex_br_taken=1, ex_p_outcome=0, RECOVER_CYCLES=1.
  - Response: cycle 0 has redirect=1, both flushes=1, bp_update=1, bp_mispredict=1; cycle 1 has if_id_flush=1 only; cycle 2 is back in RUN.
- Correct prediction:
  - Stimulus: ex_br=1, taken=predicted=1.
  - Response: bp_update=1, bp_mispredict=0, no flush.
- Memory stall:
  - Stimulus: dmem_busy=1 for 4 cycles while ex_br=1 mispredicts.
  - Response: all loads=0 for 4 cycles and no bp_update; on release, redirect=1 and exactly one bp_update.
- Reset mid-RECOVER:
  - Stimulus: drive rst=0 in cycle 1 of RECOVER with RECOVER_CYCLES=3.
  - Response: outputs=0 immediately; after release, RUN with all loads=1.
- Perf counters (PIPE_HAZARD_PERF_EN):
  - Stimulus: 3 stall cycles, 2 mispredicts, 1 load-use.
  - Response: counters read 3/2/1; with PERF_W=2, 5 stalls read 3 (saturated).
